branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- XLEN, 32, datapath width.
- TAG_W, 5, ROB tag width.
- STAGES, 2, compute pipeline depth, legal range 1..4.
- OUT_DEPTH, 2, output buffer entries, SHALL be >= STAGES; violation SHALL be an elaboration error.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clock, in, 1, sole clock.
- reset, in, 1, synchronous active-high reset.
- flush, in, 1, squash all in-flight work.
- in_valid, in, 1, issue request.
- in_ready, out, 1, block can accept.
- in_func, in, 6, ALU_FUNC code.
- in_pc, in_imm, in_rs1, in_rs2, in, XLEN each, operands.
- in_tag, in, TAG_W, ROB tag.
- in_pred_taken, in, 1, predictor direction.
- in_pred_target, in, XLEN, predicted target.
- out_valid, out, 1, result available.
- out_ready, in, 1, consumer (CDB) accepts.
- out_tag, out, TAG_W, result tag.
- out_wb_data, out, XLEN, link value.
- out_taken, out, 1, resolved direction.
- out_target, out, XLEN, resolved next PC.
- out_mispredict, out, 1, redirect required.

Function
REQ-003 A transfer SHALL occur on a rising edge of clock with in_valid && in_ready; an output pop SHALL occur with out_valid && out_ready.
REQ-004 Condition by func:
- 0x0e EQ, 0x0f NE.
- 0x10 signed LT, 0x11 signed GE.
- 0x12 unsigned LT, 0x13 unsigned GE.
- 0x14 JAL and 0x15 JALR always taken.
- Any other code SHALL resolve not-taken.
REQ-005 Taken target:
- pc+imm for 0x0e..0x14.
- (rs1+imm) with bit 0 cleared for 0x15.
- All sums modulo 2^XLEN.
REQ-006 out_target SHALL be the taken target when taken, else pc+4.
REQ-007 out_wb_data SHALL be pc+4 for 0x14/0x15, else 0.
REQ-008 out_mispredict SHALL be (taken != pred_taken) || (taken && target != pred_target).
REQ-009 Results SHALL pass through STAGES register stages, then a FIFO of OUT_DEPTH entries; with the FIFO empty and out_ready high, a result accepted at edge k SHALL present out_valid during cycle k+STAGES.
REQ-010 Occupancy counting and backpressure:
- occ SHALL count ops accepted but not yet popped.
- in_ready SHALL be (occ < OUT_DEPTH) || (occ == OUT_DEPTH && pop this cycle).
- in_ready SHALL never depend on in_valid.
REQ-011 Pipeline stages SHALL advance unconditionally; backpressure is absorbed solely by REQ-010 credit, so the FIFO SHALL never overflow.
REQ-012 Results SHALL leave in acceptance order; outputs SHALL hold stable while out_valid && !out_ready.
REQ-013 Simultaneous push and pop on a full FIFO SHALL be legal and leave occ unchanged.
REQ-014 Flush:
- flush high at an edge SHALL invalidate all pipeline stages and FIFO entries, and set occ to 0.
- A same-cycle input transfer SHALL be discarded.
- A same-cycle pop SHALL still complete.
- out_valid SHALL be 0 in the following cycle.

Reset
REQ-015 With reset high at an edge:
- occ, the FIFO pointers and all stage valid bits SHALL clear.
- out_valid SHALL be 0 and in_ready SHALL be 1 the next cycle.
- The remaining outputs SHALL be 0.
REQ-016 Reset SHALL take priority over flush and over any transfer, including mid-pipeline.

Configuration
REQ-017 Macro BRU_STATS_EN defined adds 32-bit outputs stat_resolved and stat_mispred:
- Each counter SHALL increment on every pop (stat_mispred only when out_mispredict=1).
- Counters SHALL wrap at 2^32, clear on reset, and SHALL not clear on flush.
REQ-018 Without BRU_STATS_EN, those ports and counters SHALL be absent, with no other behavioural change.

Structure
REQ-019 ALU_FUNC codes, XLEN and tag width SHALL live in sys_defs.svh; no new constants SHALL be local duplicates.
REQ-020 Condition/target/link computation SHALL be one combinational sub-module, bru_resolve_comb, instantiated before stage 1.

Verification
REQ-021 The bench SHALL cover these directed scenarios (stimulus -> required response):
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120 -> taken=1, target=0x120, mispredict=0, out_valid at k+STAGES.
- BLT, rs1=0xFFFFFFFF, rs2=1, pred_taken=0 -> taken=1, mispredict=1; same operands with BLTU -> taken=0, target=pc+4, mispredict=0.
- JALR, rs1=0x1003, imm=0, pc=0x40, pred_target=0x1002 -> target=0x1002, wb_data=0x44, mispredict=0.
- out_ready held low, OUT_DEPTH+2 requests offered -> exactly OUT_DEPTH accepted, in_ready=0 thereafter, in-order drain once out_ready rises.
- Three ops in flight, flush asserted with in_valid=1 -> out_valid=0 next cycle, occ=0, the new op is not produced.
- BRU_STATS_EN defined, 4 pops with 1 mispredict -> stat_resolved=4, stat_mispred=1; unchanged after flush, 0 after reset.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for branch_resolve_unit (optional BRU_STATS_EN adds pop counters in the top).
`include "sys_defs.svh"

package branch_resolve_unit_pkg;

   localparam int FUNC_W = `ALU_FUNC_W;

   typedef enum logic [FUNC_W-1:0] {
      FUNC_BEQ  = `ALU_BEQ,
      FUNC_BNE  = `ALU_BNE,
      FUNC_BLT  = `ALU_BLT,
      FUNC_BGE  = `ALU_BGE,
      FUNC_BLTU = `ALU_BLTU,
      FUNC_BGEU = `ALU_BGEU,
      FUNC_JAL  = `ALU_JAL,
      FUNC_JALR = `ALU_JALR
   } alu_func_e;

   function automatic logic is_jump(input logic [FUNC_W-1:0] func);
      return (func == FUNC_JAL) || (func == FUNC_JALR);
   endfunction

endpackage

// File: rtl/bru_resolve_comb.sv
// Combinational branch resolution: condition, taken target, link value and mispredict flag.
`include "sys_defs.svh"

module bru_resolve_comb
   import branch_resolve_unit_pkg::*;
#(
   parameter int XLEN = `XLEN
)(
   input  logic [FUNC_W-1:0] func,
   input  logic [XLEN-1:0]   pc,
   input  logic [XLEN-1:0]   imm,
   input  logic [XLEN-1:0]   rs1,
   input  logic [XLEN-1:0]   rs2,
   input  logic              pred_taken,
   input  logic [XLEN-1:0]   pred_target,
   output logic              taken,
   output logic [XLEN-1:0]   target,
   output logic [XLEN-1:0]   wb_data,
   output logic              mispredict
);

   logic [XLEN-1:0] link;
   logic [XLEN-1:0] br_target;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] jalr_target;
   logic [XLEN-1:0] taken_target;
   logic            cond;

   assign link        = pc + XLEN'(4);
   assign br_target   = pc + imm;
   assign jalr_sum    = rs1 + imm;
   assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};

   always_comb begin
      cond = 1'b0;
      case (func)
         FUNC_BEQ:            cond = (rs1 == rs2);
         FUNC_BNE:            cond = (rs1 != rs2);
         FUNC_BLT:            cond = ($signed(rs1) <  $signed(rs2));
         FUNC_BGE:            cond = ($signed(rs1) >= $signed(rs2));
         FUNC_BLTU:           cond = (rs1 <  rs2);
         FUNC_BGEU:           cond = (rs1 >= rs2);
         FUNC_JAL, FUNC_JALR: cond = 1'b1;
         default:             cond = 1'b0;
      endcase
   end

   assign taken_target = (func == FUNC_JALR) ? jalr_target : br_target;

   assign taken      = cond;
   assign target     = cond ? taken_target : link;
   assign wb_data    = is_jump(func) ? link : '0;
   // A correct direction with a wrong target still needs a redirect.
   assign mispredict = (cond != pred_taken) || (cond && (taken_target != pred_target));

endmodule

// File: rtl/sys_defs.svh
// System-wide constants: datapath width, ROB tag width and ALU_FUNC encodings.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define XLEN       32
`define TAG_W      5
`define ALU_FUNC_W 6

`define ALU_BEQ  6'h0e
`define ALU_BNE  6'h0f
`define ALU_BLT  6'h10
`define ALU_BGE  6'h11
`define ALU_BLTU 6'h12
`define ALU_BGEU 6'h13
`define ALU_JAL  6'h14
`define ALU_JALR 6'h15

`endif

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolve, STAGES-deep pipeline, credit-managed output FIFO.
// Define BRU_STATS_EN to add the stat_resolved / stat_mispred pop counters.
`include "sys_defs.svh"

module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int XLEN      = `XLEN,
   parameter int TAG_W     = `TAG_W,
   parameter int STAGES    = 2,
   parameter int OUT_DEPTH = 2
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [FUNC_W-1:0] in_func,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [XLEN-1:0]   in_rs1,
   input  logic [XLEN-1:0]   in_rs2,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic              in_pred_taken,
   input  logic [XLEN-1:0]   in_pred_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [TAG_W-1:0]  out_tag,
   output logic [XLEN-1:0]   out_wb_data,
   output logic              out_taken,
   output logic [XLEN-1:0]   out_target,
   output logic              out_mispredict
`ifdef BRU_STATS_EN
   ,
   output logic [31:0]       stat_resolved,
   output logic [31:0]       stat_mispred
`endif
);

   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int OCC_W = $clog2(OUT_DEPTH + 1);

   generate
      if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
         $error("branch_resolve_unit: STAGES must be in 1..4");
      end
      if (OUT_DEPTH < STAGES) begin : g_bad_depth
         $error("branch_resolve_unit: OUT_DEPTH must be >= STAGES");
      end
   endgenerate

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  wb_data;
      logic             taken;
      logic [XLEN-1:0]  target;
      logic             mispredict;
   } res_t;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   logic              comb_taken;
   logic              comb_mispredict;
   logic [XLEN-1:0]   comb_target;
   logic [XLEN-1:0]   comb_wb_data;
   res_t              res_comb;

   logic [STAGES:1]   vld_p;
   res_t              res_p [1:STAGES];

   res_t              fifo_mem [OUT_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [OCC_W-1:0]  fifo_cnt;
   logic [OCC_W-1:0]  occ;

   logic              xfer;
   logic              push;
   logic              pop;

   // Stage 0: combinational resolve of the issuing op
   bru_resolve_comb #(.XLEN(XLEN)) u_resolve (
      .func        (in_func),
      .pc          (in_pc),
      .imm         (in_imm),
      .rs1         (in_rs1),
      .rs2         (in_rs2),
      .pred_taken  (in_pred_taken),
      .pred_target (in_pred_target),
      .taken       (comb_taken),
      .target      (comb_target),
      .wb_data     (comb_wb_data),
      .mispredict  (comb_mispredict)
   );

   always_comb begin
      res_comb            = '0;
      res_comb.tag        = in_tag;
      res_comb.wb_data    = comb_wb_data;
      res_comb.taken      = comb_taken;
      res_comb.target     = comb_target;
      res_comb.mispredict = comb_mispredict;
   end

   // Credit covers pipeline plus FIFO, so a full FIFO can still accept if it pops this cycle.
   assign pop      = out_valid && out_ready;
   assign in_ready = (occ < OCC_W'(OUT_DEPTH)) || ((occ == OCC_W'(OUT_DEPTH)) && pop);
   assign xfer     = in_valid && in_ready;
   assign push     = vld_p[STAGES];

   // Stages 1..STAGES: free-running shift, no stall path
   always_ff @(posedge clock) begin
      if (reset || flush) begin
         vld_p <= '0;
      end else begin
         vld_p[1] <= xfer;
         for (int s = 2; s <= STAGES; s++) begin
            vld_p[s] <= vld_p[s-1];
         end
      end
   end

   always_ff @(posedge clock) begin
      res_p[1] <= res_comb;
      for (int s = 2; s <= STAGES; s++) begin
         res_p[s] <= res_p[s-1];
      end
   end

   // Output FIFO and occupancy credit
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr] <= res_p[STAGES];
      end
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         occ      <= '0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         fifo_cnt <= fifo_cnt + OCC_W'(push) - OCC_W'(pop);
         occ      <= occ + OCC_W'(xfer) - OCC_W'(pop);
      end
   end

   assign out_valid      = (fifo_cnt != '0);
   assign out_tag        = out_valid ? fifo_mem[rd_ptr].tag        : '0;
   assign out_wb_data    = out_valid ? fifo_mem[rd_ptr].wb_data    : '0;
   assign out_taken      = out_valid ? fifo_mem[rd_ptr].taken      : 1'b0;
   assign out_target     = out_valid ? fifo_mem[rd_ptr].target     : '0;
   assign out_mispredict = out_valid ? fifo_mem[rd_ptr].mispredict : 1'b0;

`ifdef BRU_STATS_EN
   // Counters survive flush; only reset clears them.
   always_ff @(posedge clock) begin
      if (reset) begin
         stat_resolved <= '0;
         stat_mispred  <= '0;
      end else if (pop) begin
         stat_resolved <= stat_resolved + 32'd1;
         if (out_mispredict) stat_mispred <= stat_mispred + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: vector table plus scoreboard queue.
module tb_branch_resolve_unit;

   localparam int XLEN      = 32;
   localparam int TAG_W     = 5;
   localparam int STAGES    = 2;
   localparam int OUT_DEPTH = 2;

   logic             clock = 1'b0;
   logic             reset, flush, in_valid, in_ready;
   logic [5:0]       in_func;
   logic [XLEN-1:0]  in_pc, in_imm, in_rs1, in_rs2, in_pred_target;
   logic [TAG_W-1:0] in_tag;
   logic             in_pred_taken;
   logic             out_valid, out_ready, out_taken, out_mispredict;
   logic [TAG_W-1:0] out_tag;
   logic [XLEN-1:0]  out_wb_data, out_target;
`ifdef BRU_STATS_EN
   logic [31:0]      stat_resolved, stat_mispred;
`endif

   always #5 clock = ~clock;

   branch_resolve_unit #(
      .XLEN(XLEN), .TAG_W(TAG_W), .STAGES(STAGES), .OUT_DEPTH(OUT_DEPTH)
   ) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
      .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_tag(in_tag), .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
      .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
      .out_wb_data(out_wb_data), .out_taken(out_taken), .out_target(out_target),
      .out_mispredict(out_mispredict)
`ifdef BRU_STATS_EN
      , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
   );

   typedef struct {
      logic [5:0]  func;
      logic [31:0] pc, imm, rs1, rs2;
      logic        pt;
      logic [31:0] ptgt;
      logic        taken;
      logic [31:0] target, wb;
      logic        mp;
   } vec_t;

   typedef struct {
      logic [4:0]  tag;
      logic        taken;
      logic [31:0] target, wb;
      logic        mp;
   } exp_t;

   vec_t vecs [12];
   exp_t sbq [$];
   int   checks = 0;
   int   errors = 0;
   int   pops_seen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic set_vec(input int i, input logic [5:0] f,
                          input logic [31:0] pc, imm, rs1, rs2,
                          input logic pt, input logic [31:0] ptgt,
                          input logic tk, input logic [31:0] tgt, wb, input logic mp);
      vecs[i] = '{func: f, pc: pc, imm: imm, rs1: rs1, rs2: rs2, pt: pt, ptgt: ptgt,
                  taken: tk, target: tgt, wb: wb, mp: mp};
   endtask

   task automatic drive_vec(input int idx, input logic [4:0] tag);
      in_func        = vecs[idx].func;
      in_pc          = vecs[idx].pc;
      in_imm         = vecs[idx].imm;
      in_rs1         = vecs[idx].rs1;
      in_rs2         = vecs[idx].rs2;
      in_pred_taken  = vecs[idx].pt;
      in_pred_target = vecs[idx].ptgt;
      in_tag         = tag;
      in_valid       = 1'b1;
   endtask

   task automatic push_exp(input int idx, input logic [4:0] tag);
      exp_t e;
      e.tag    = tag;
      e.taken  = vecs[idx].taken;
      e.target = vecs[idx].target;
      e.wb     = vecs[idx].wb;
      e.mp     = vecs[idx].mp;
      sbq.push_back(e);
   endtask

   task automatic issue(input int idx, input logic [4:0] tag);
      bit done;
      done = 1'b0;
      drive_vec(idx, tag);
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clock);
         if (in_ready) begin
            @(posedge clock); #1;
            push_exp(idx, tag);
            done = 1'b1;
         end else begin
            @(posedge clock); #1;
         end
      end
      in_valid = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL issue_timeout: tag 0x%0h not accepted within 50 cycles", tag);
      end
   endtask

   task automatic drain(input string name);
      int c;
      c = 0;
      while ((sbq.size() != 0 || out_valid) && c < 200) begin
         @(posedge clock); #1;
         c++;
      end
      check(name, 64'(sbq.size()), 64'd0);
   endtask

   // Scoreboard: every pop is compared against the oldest expected result.
   always @(negedge clock) begin : monitor
      exp_t e;
      if (!reset && out_valid && out_ready) begin
         pops_seen++;
         if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got tag 0x%0h, required no output", out_tag);
         end else begin
            e = sbq.pop_front();
            check("out_tag",        64'(out_tag),        64'(e.tag));
            check("out_taken",      64'(out_taken),      64'(e.taken));
            check("out_target",     64'(out_target),     64'(e.target));
            check("out_wb_data",    64'(out_wb_data),    64'(e.wb));
            check("out_mispredict", 64'(out_mispredict), 64'(e.mp));
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int acc;
      int p;
      bit got;

      //        idx func    pc          imm         rs1         rs2         pt ptgt        tk target      wb          mp
      set_vec(0,  6'h0e, 32'h100,      32'h20,      32'd5,       32'd5,       1, 32'h120,     1, 32'h120,     32'h0,  0);
      set_vec(1,  6'h10, 32'h200,      32'h10,      32'hFFFFFFFF,32'd1,       0, 32'h0,       1, 32'h210,     32'h0,  1);
      set_vec(2,  6'h12, 32'h200,      32'h10,      32'hFFFFFFFF,32'd1,       0, 32'h0,       0, 32'h204,     32'h0,  0);
      set_vec(3,  6'h15, 32'h40,       32'h0,       32'h1003,    32'h0,       1, 32'h1002,    1, 32'h1002,    32'h44, 0);
      set_vec(4,  6'h0f, 32'h300,      32'h8,       32'd3,       32'd3,       1, 32'h308,     0, 32'h304,     32'h0,  1);
      set_vec(5,  6'h11, 32'h400,      32'hFFFFFFF0,32'hFFFFFFFE,32'hFFFFFFFE,1, 32'h3F0,     1, 32'h3F0,     32'h0,  0);
      set_vec(6,  6'h13, 32'h500,      32'h40,      32'd1,       32'hFFFFFFFF,1, 32'h540,     0, 32'h504,     32'h0,  1);
      set_vec(7,  6'h14, 32'hFFFFFFFC, 32'h8,       32'h0,       32'h0,       1, 32'h4,       1, 32'h4,       32'h0,  0);
      set_vec(8,  6'h00, 32'h600,      32'h10,      32'd9,       32'd9,       0, 32'h0,       0, 32'h604,     32'h0,  0);
      set_vec(9,  6'h0e, 32'h700,      32'h100,     32'd7,       32'd7,       1, 32'h704,     1, 32'h800,     32'h0,  1);
      set_vec(10, 6'h10, 32'h80,       32'h20,      32'd1,       32'hFFFFFFFF,1, 32'hA0,      0, 32'h84,      32'h0,  1);
      set_vec(11, 6'h15, 32'h10,       32'hFFFFFFFF,32'h2000,    32'h0,       1, 32'h1FFE,    1, 32'h1FFE,    32'h14, 0);

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_func = '0; in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0;
      in_tag = '0; in_pred_taken = 1'b0; in_pred_target = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      check("rst_out_valid",  64'(out_valid),      64'd0);
      check("rst_in_ready",   64'(in_ready),       64'd1);
      check("rst_out_tag",    64'(out_tag),        64'd0);
      check("rst_out_wb",     64'(out_wb_data),    64'd0);
      check("rst_out_taken",  64'(out_taken),      64'd0);
      check("rst_out_target", 64'(out_target),     64'd0);
      check("rst_out_mp",     64'(out_mispredict), 64'd0);
`ifdef BRU_STATS_EN
      check("rst_stat_resolved", 64'(stat_resolved), 64'd0);
      check("rst_stat_mispred",  64'(stat_mispred),  64'd0);
`endif

      // Latency: accepted at edge k, visible after edge k+STAGES
      drive_vec(0, 5'd1);
      @(negedge clock);
      check("lat_in_ready", 64'(in_ready), 64'd1);
      @(posedge clock); #1;
      push_exp(0, 5'd1);
      in_valid = 1'b0;
      repeat (STAGES - 1) @(posedge clock);
      #1;
      check("lat_early_valid", 64'(out_valid), 64'd0);
      @(posedge clock); #1;
      check("lat_out_valid", 64'(out_valid), 64'd1);

      for (int i = 1; i <= 3; i++) issue(i, 5'(i + 1));
      drain("drain_first4");
`ifdef BRU_STATS_EN
      check("stat_resolved_4", 64'(stat_resolved), 64'd4);
      check("stat_mispred_1",  64'(stat_mispred),  64'd1);
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      check("stat_resolved_flush", 64'(stat_resolved), 64'd4);
      check("stat_mispred_flush",  64'(stat_mispred),  64'd1);
`endif

      // Full table, back to back
      for (int i = 0; i < 12; i++) issue(i, 5'(i + 8));
      drain("drain_table");

      // Backpressure: only OUT_DEPTH credits with the consumer stalled
      out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < OUT_DEPTH + 2; i++) begin
         drive_vec(4 + i, 5'(i + 24));
         got = 1'b0;
         @(negedge clock);
         if (in_ready) begin
            acc++;
            got = 1'b1;
         end
         @(posedge clock); #1;
         if (got) push_exp(4 + i, 5'(i + 24));
      end
      in_valid = 1'b0;
      check("bp_accepted", 64'(acc), 64'(OUT_DEPTH));
      repeat (4) @(posedge clock);
      #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      for (int c = 0; c < 2; c++) begin
         if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL bp_hold_tag: got empty scoreboard, required pending entry");
         end else begin
            check("bp_hold_tag", 64'(out_tag), 64'(sbq[0].tag));
         end
         @(posedge clock); #1;
      end
      out_ready = 1'b1;
      drain("drain_bp");

      // Flush with work in flight and a same-cycle issue
      issue(8, 5'd20);
      issue(9, 5'd21);
      issue(10, 5'd22);
      drive_vec(11, 5'd23);
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      sbq.delete();
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_occ", 64'(dut.occ), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      p = pops_seen;
      repeat (8) @(posedge clock);
      #1;
      check("flush_no_output", 64'(pops_seen), 64'(p));

      // Reset mid-pipeline beats a same-cycle issue
      issue(0, 5'd30);
      drive_vec(1, 5'd31);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      in_valid = 1'b0;
      sbq.delete();
      check("mrst_out_valid", 64'(out_valid), 64'd0);
      check("mrst_in_ready", 64'(in_ready), 64'd1);
      check("mrst_out_target", 64'(out_target), 64'd0);
      p = pops_seen;
      repeat (6) @(posedge clock);
      #1;
      check("mrst_no_output", 64'(pops_seen), 64'(p));
`ifdef BRU_STATS_EN
      check("stat_resolved_rst", 64'(stat_resolved), 64'd0);
      check("stat_mispred_rst",  64'(stat_mispred),  64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
